turn_signal_ctrl: RTL and testbench
===================================

# turn_signal_ctrl

Turn-signal sequencer that sits behind the turn-direction latch and drives the two lamp outputs. It arbitrates among left, right and hazard requests and generates a fixed blink cadence from a cycle prescaler. It also enforces a minimum number of flashes so that a short lane-change tap still produces a visible signal.

## Interface

- BLINK_HALF, default 8: cycles per half-period; on time equals off time. Must be ≥2.
- MIN_FLASHES, default 3: minimum complete on-phases for a left/right sequence. Must be ≥1.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_l  in  1  left request (level).
- req_r  in  1  right request (level).
- hazard  in  1  hazard request (level); highest priority.
- lamp_l  out  1  left lamp.
- lamp_r  out  1  right lamp.
- busy  out  1  high whenever state ≠ IDLE.
- active_dir  out  2  00 idle, 01 left, 10 right, 11 hazard.

## Operation

- Registers: state (IDLE/LEFT/RIGHT/HAZARD), phase counter 0..BLINK_HALF-1, phase bit (1=on), flash counter saturating at MIN_FLASHES.
- Outputs decode from registers only:
  - lamp_l = phase & (state ∈ {LEFT, HAZARD}).
  - lamp_r = phase & (state ∈ {RIGHT, HAZARD}).
- Phase counter counts every cycle outside IDLE. At BLINK_HALF-1 it wraps to 0 and toggles phase. The flash counter increments on the on→off toggle.
- Entering any non-IDLE state: phase counter = 0, phase = 1, flash counter = 0.
- IDLE:
  - hazard → HAZARD.
  - req_l & ~req_r → LEFT.
  - req_r & ~req_l → RIGHT.
  - req_l & req_r (without hazard) is invalid; stay in IDLE.
- LEFT/RIGHT:
  - hazard → HAZARD immediately, with phase restart.
  - The opposite-direction request is ignored. A direction change passes through IDLE.
  - Exit to IDLE at the edge ending an off half-period (phase=0, counter=BLINK_HALF-1) when the own request is low and the flash counter (including flashes completed that cycle) ≥ MIN_FLASHES.
  - Otherwise keep flashing.
- HAZARD: exit to IDLE at the edge ending an off half-period when hazard is low. No minimum flash count applies. On exit, a pending req_l/req_r is re-evaluated from IDLE on the following cycle.
- In IDLE: counters held at 0, phase = 0.

## Timing

- Reset: state IDLE, counters 0, phase 0. lamp_l = lamp_r = busy = 0 and active_dir = 00 in the cycle after the rst edge. Reset mid-sequence aborts immediately, with no completion of the current half-period.
- Request latency: a request sampled at edge k causes the lamp to go high in the cycle following edge k. The lamp stays high exactly BLINK_HALF cycles, then low BLINK_HALF cycles.
- Minimum sequence with a 1-cycle request pulse: MIN_FLASHES × 2 × BLINK_HALF cycles of non-IDLE. busy goes low at the edge ending the last off half-period.
- Hazard preemption: hazard asserted while in LEFT/RIGHT causes both lamps to be high the next cycle, regardless of the current phase.
- Exit is only ever at an off-phase boundary, so no lamp is truncated mid on-phase except by hazard preemption or reset.
- req_l/req_r/hazard sampled only at clock edges. Glitches between edges have no effect.

## Test plan

- BLINK_HALF=4, MIN_FLASHES=3. After reset, pulse req_l for 1 cycle. Required response:
  - lamp_l pattern is 4 high / 4 low, ×3.
  - busy high for exactly 24 cycles, then active_dir = 00.
  - lamp_r stays 0 throughout.
- Hold req_r for 40 cycles, then drop it. Required response:
  - Flashing continues.
  - Return to IDLE at the first off-phase end after the drop, at cycle 48.
- Assert req_l and req_r in the same cycle from IDLE. Required response: state stays IDLE and both lamps stay 0. Then assert hazard: both lamps go high the next cycle, with active_dir = 11.
- In LEFT, 2 cycles into an on-phase, assert hazard. Required response:
  - The next cycle, lamp_l = lamp_r = 1 for 4 cycles (phase restarted).
  - Drop hazard: exit at the end of the current/next off half-period. If req_l is still high, re-enter LEFT one cycle later.
- Mid on-phase in RIGHT, assert rst for 1 cycle. Required response: all outputs are 0 the next cycle. The sequence does not resume after rst is released unless req_r is still high.
- In LEFT, assert req_r alone. Required response: it is ignored (lamp_r = 0) until LEFT completes. RIGHT starts on the cycle after IDLE is reached.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turn_signal_ctrl
// Description : Turn-signal sequencer. Arbitrates left / right / hazard
//               requests, generates a symmetric blink cadence from a cycle
//               prescaler and enforces a minimum number of flashes for
//               left/right sequences.
// Ports       : clk        - clock, all state changes on rising edge
//               rst        - synchronous active-high reset
//               req_l      - left request (level)
//               req_r      - right request (level)
//               hazard     - hazard request (level), highest priority
//               lamp_l     - left lamp
//               lamp_r     - right lamp
//               busy       - high whenever the sequencer is not idle
//               active_dir - 00 idle, 01 left, 10 right, 11 hazard
// Revision    : 1.0 - initial release
// ============================================================================
module turn_signal_ctrl #(
    parameter int BLINK_HALF  = 8,
    parameter int MIN_FLASHES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_l,
    input  logic       req_r,
    input  logic       hazard,
    output logic       lamp_l,
    output logic       lamp_r,
    output logic       busy,
    output logic [1:0] active_dir
);

    localparam int c_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int c_FL_W  = $clog2(MIN_FLASHES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_FL_W-1:0]  c_FL_MIN   = c_FL_W'(MIN_FLASHES);
    localparam logic [c_FL_W-1:0]  c_FL_ONE   = c_FL_W'(1);

    // State codes double as the active_dir encoding.
    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_LEFT   = 2'b01;
    localparam logic [1:0] c_ST_RIGHT  = 2'b10;
    localparam logic [1:0] c_ST_HAZARD = 2'b11;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;
    logic [c_FL_W-1:0]  r_flash;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_phase_nxt;
    logic [c_FL_W-1:0]  w_flash_nxt;
    logic               w_enter;
    logic               w_go_idle;
    logic               w_own_req;
    logic               w_wrap;
    logic               w_end_off;
    logic               w_flash_done;

    assign w_wrap       = (r_cnt == c_CNT_LAST);
    assign w_end_off    = w_wrap & ~r_phase;
    // The flash counter only advances on an on->off toggle, so at the end of
    // an off half-period it already includes every completed flash.
    assign w_flash_done = (r_flash >= c_FL_MIN);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_flash <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_flash <= w_flash_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_flash_nxt = r_flash;
        w_enter     = 1'b0;
        w_go_idle   = 1'b0;
        w_own_req   = (r_state == c_ST_LEFT) ? req_l : req_r;

        case (r_state)
            c_ST_IDLE: begin
                // Simultaneous left+right without hazard is invalid: stay idle.
                if (hazard) begin
                    w_state_nxt = c_ST_HAZARD;
                    w_enter     = 1'b1;
                end else if (req_l & ~req_r) begin
                    w_state_nxt = c_ST_LEFT;
                    w_enter     = 1'b1;
                end else if (req_r & ~req_l) begin
                    w_state_nxt = c_ST_RIGHT;
                    w_enter     = 1'b1;
                end
            end
            c_ST_LEFT, c_ST_RIGHT: begin
                // Opposite-direction request is deliberately ignored here.
                if (hazard) begin
                    w_state_nxt = c_ST_HAZARD;
                    w_enter     = 1'b1;
                end else if (w_end_off & ~w_own_req & w_flash_done) begin
                    w_go_idle = 1'b1;
                end
            end
            c_ST_HAZARD: begin
                if (w_end_off & ~hazard) begin
                    w_go_idle = 1'b1;
                end
            end
            default: begin
                w_go_idle = 1'b1;
            end
        endcase

        if (w_enter) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b1;
            w_flash_nxt = '0;
        end else if (w_go_idle) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
            w_flash_nxt = '0;
        end else if (r_state != c_ST_IDLE) begin
            if (w_wrap) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
                if (r_phase && (r_flash != c_FL_MIN)) begin
                    w_flash_nxt = r_flash + c_FL_ONE;
                end
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decode from registers only
    // ------------------------------------------------------------------
    assign lamp_l     = r_phase & ((r_state == c_ST_LEFT)  | (r_state == c_ST_HAZARD));
    assign lamp_r     = r_phase & ((r_state == c_ST_RIGHT) | (r_state == c_ST_HAZARD));
    assign busy       = (r_state != c_ST_IDLE);
    assign active_dir = r_state;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_signal_ctrl
// Description : Self-checking bench for turn_signal_ctrl. A time-based model
//               (mode plus cycles elapsed since entering it) predicts all
//               outputs every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_signal_ctrl;

    localparam int BH  = 4;
    localparam int MF  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_l = 1'b0;
    logic       req_r = 1'b0;
    logic       hazard = 1'b0;
    logic       lamp_l;
    logic       lamp_r;
    logic       busy;
    logic [1:0] active_dir;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    turn_signal_ctrl #(.BLINK_HALF(BH), .MIN_FLASHES(MF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_l      (req_l),
        .req_r      (req_r),
        .hazard     (hazard),
        .lamp_l     (lamp_l),
        .lamp_r     (lamp_r),
        .busy       (busy),
        .active_dir (active_dir)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 left, 2 right, 3 hazard; t: cycles spent in mode.
    typedef struct packed {
        int mode;
        int t;
    } mstate_t;

    mstate_t m = '{mode: 0, t: 0};

    function automatic mstate_t model_step(mstate_t s, logic rl, logic rr, logic hz);
        mstate_t n;
        bit      off_end;
        int      flashes;
        bit      own;
        n       = s;
        off_end = ((s.t + 1) % (2 * BH)) == 0;
        flashes = (s.t + 1 + BH) / (2 * BH);
        own     = (s.mode == 1) ? rl : rr;
        case (s.mode)
            0: begin
                if (hz)             n = '{mode: 3, t: 0};
                else if (rl && !rr) n = '{mode: 1, t: 0};
                else if (rr && !rl) n = '{mode: 2, t: 0};
            end
            1, 2: begin
                if (hz)                                n = '{mode: 3, t: 0};
                else if (off_end && !own && flashes >= MF) n = '{mode: 0, t: 0};
                else                                   n.t = s.t + 1;
            end
            default: begin
                if (off_end && !hz) n = '{mode: 0, t: 0};
                else                n.t = s.t + 1;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) m <= '{mode: 0, t: 0};
        else     m <= model_step(m, req_l, req_r, hazard);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit on;
            on = (m.mode != 0) && (((m.t / BH) % 2) == 0);
            chk("model_lamp_l", int'(lamp_l), int'(on && (m.mode == 1 || m.mode == 3)));
            chk("model_lamp_r", int'(lamp_r), int'(on && (m.mode == 2 || m.mode == 3)));
            chk("model_busy",   int'(busy),   int'(m.mode != 0));
            chk("model_dir",    int'(active_dir), m.mode);
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_timeout"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_lamps", int'({lamp_l, lamp_r}), 0);
        chk("reset_dir", int'(active_dir), 0);
        rst = 1'b0;

        // 1-cycle left pulse: 3 flashes of 4 on / 4 off, 24 busy cycles.
        req_l = 1'b1;
        @(negedge clk);
        req_l = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            chk("pulse_lamp_l", int'(lamp_l), int'((n % 8) < 4));
            chk("pulse_lamp_r", int'(lamp_r), 0);
            n++;
            @(negedge clk);
        end
        chk("pulse_busy_len", n, 24);
        chk("pulse_dir_after", int'(active_dir), 0);

        // Held right request: drop after 41 sampled edges -> 48 busy cycles.
        repeat (2) @(negedge clk);
        req_r = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 41) req_r = 1'b0;
            @(negedge clk);
        end
        req_r = 1'b0;
        chk("held_busy_len", n, 48);

        // Invalid left+right from idle, then hazard.
        req_l = 1'b1;
        req_r = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("both_req_busy", int'(busy), 0);
            chk("both_req_lamps", int'({lamp_l, lamp_r}), 0);
        end
        hazard = 1'b1;
        @(negedge clk);
        chk("haz_lamps", int'({lamp_l, lamp_r}), 3);
        chk("haz_dir", int'(active_dir), 3);
        hazard = 1'b0;
        req_l  = 1'b0;
        req_r  = 1'b0;
        wait_idle("haz_exit");

        // Hazard preemption 2 cycles into a left on-phase.
        @(negedge clk);
        req_l = 1'b1;
        repeat (3) @(negedge clk);
        hazard = 1'b1;
        @(negedge clk);
        repeat (4) begin
            chk("preempt_lamps_on", int'({lamp_l, lamp_r}), 3);
            @(negedge clk);
        end
        chk("preempt_lamps_off", int'({lamp_l, lamp_r}), 0);
        hazard = 1'b0;
        wait_idle("preempt_exit");
        @(negedge clk);
        chk("reenter_left", int'(active_dir), 1);
        req_l = 1'b0;
        wait_idle("reenter_exit");

        // Reset mid on-phase of right.
        @(negedge clk);
        req_r = 1'b1;
        repeat (2) @(negedge clk);
        req_r = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", int'({lamp_l, lamp_r, busy, active_dir}), 0);
        @(negedge clk);
        chk("rst_no_resume", int'(busy), 0);

        // Right requested during left is ignored until left completes.
        req_l = 1'b1;
        @(negedge clk);
        req_l = 1'b0;
        repeat (3) @(negedge clk);
        req_r = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            chk("ignore_r_lamp", int'(lamp_r), 0);
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("right_after_left", int'(active_dir), 2);
        req_r = 1'b0;
        wait_idle("right_exit");

        // Randomized level-request traffic, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0) req_l  = ~req_l;
            if ($urandom_range(0, 29) == 0) req_r  = ~req_r;
            if ($urandom_range(0, 59) == 0) hazard = ~hazard;
        end
        rst    = 1'b0;
        req_l  = 1'b0;
        req_r  = 1'b0;
        hazard = 1'b0;
        wait_idle("final_exit");
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
